// File: rtl/csr_mtrap_pkg.sv
// Shared constants and types for the machine-mode CSR/trap unit:
// CSR addresses, interrupt cause codes, mstatus/mtvec layouts.
package csr_mtrap_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MCNTINH   = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam logic [4:0] IRQ_MSI        = 5'd3;
  localparam logic [4:0] IRQ_MTI        = 5'd7;
  localparam logic [4:0] IRQ_MEI        = 5'd11;
  localparam logic [4:0] IRQ_LOCAL_BASE = 5'd16;

  // MXL=1 (RV32), extensions I and M
  localparam logic [31:0] MISA_VAL = 32'h4000_1100;

  typedef struct packed {
    logic mpie;
    logic mie;
  } mstatus_t;

  typedef struct packed {
    logic [29:0] base;
    logic [1:0]  mode;
  } mtvec_t;

  localparam mstatus_t MSTATUS_INIT = '{mpie: 1'b0, mie: 1'b0};

  function automatic logic [31:0] mstatus_read(input mstatus_t s);
    return {19'b0, 2'b11, 3'b0, s.mpie, 3'b0, s.mie, 3'b0};
  endfunction

  // Only direct (0) and vectored (1) modes exist; anything else collapses to direct.
  function automatic mtvec_t mtvec_legalise(input logic [31:0] w);
    mtvec_t t;
    t.base = w[31:2];
    t.mode = w[1] ? 2'b00 : w[1:0];
    return t;
  endfunction

endpackage

// File: rtl/csr_irq_arb.sv
// Fixed-priority interrupt arbiter: bit 0 MEI, 1 MSI, 2 MTI, 3+k local line k.
// Priority MEI > MSI > MTI > highest local line > ... > local line 0.
module csr_irq_arb
  import csr_mtrap_pkg::*;
#(
  parameter int N_LOCAL = 16
) (
  input  logic [N_LOCAL+2:0] pend_i,
  output logic               valid_o,
  output logic [4:0]         code_o
);

  always_comb begin
    valid_o = |pend_i;
    code_o  = 5'd0;
    // Later assignments override earlier ones, so scan from lowest priority up.
    for (int k = 0; k < N_LOCAL; k++) begin
      if (pend_i[3+k]) code_o = IRQ_LOCAL_BASE + 5'(k);
    end
    if (pend_i[2]) code_o = IRQ_MTI;
    if (pend_i[1]) code_o = IRQ_MSI;
    if (pend_i[0]) code_o = IRQ_MEI;
  end

endmodule

// File: rtl/csr_mtrap.sv
// RV32 machine-mode CSR file and trap/return unit with local interrupt lines,
// vectored mtvec, mcountinhibit and configurable-width counters.
module csr_mtrap
  import csr_mtrap_pkg::*;
#(
  parameter int          N_LOCAL   = 16,
  parameter int          CNT_WIDTH = 64,
  parameter logic [31:0] RST_MTVEC = 32'h0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  rden,
  input  logic [11:0]                           raddr,
  output logic [31:0]                           rdata,
  input  logic                                  wren,
  input  logic [11:0]                           waddr,
  input  logic [31:0]                           wdata,
  input  logic                                  retire,
  input  logic                                  exc,
  input  logic [4:0]                            ecause,
  input  logic [31:0]                           epc,
  input  logic [31:0]                           etval,
  input  logic                                  mret,
  input  logic                                  meip,
  input  logic                                  mtip,
  input  logic                                  msip,
  input  logic [(N_LOCAL > 0 ? N_LOCAL : 1)-1:0] lirq,
  output logic                                  trap,
  output logic                                  ret,
  output logic [31:0]                           trap_pc,
  output logic [31:0]                           mepc_o
);

  localparam logic [31:0] IRQ_MASK =
    32'h0000_0888 | (32'((64'd1 << N_LOCAL) - 64'd1) << 16);
  localparam bit HAS_HI = (CNT_WIDTH > 32);

  mstatus_t    mstatus_q, mstatus_d;
  mtvec_t      mtvec_q, mtvec_d;
  logic [31:0] mie_q, mie_d, mip_q, mip_d;
  logic [31:0] mscratch_q, mscratch_d, mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d;
  logic [31:0] mcntinh_q, mcntinh_d;
  logic        trap_q, ret_q;
  logic [31:0] trap_pc_q, trap_pc_d;

  logic [N_LOCAL+2:0] pend;
  logic               irq_valid, take_irq, take_trap, do_mret;
  logic [4:0]         irq_code;
  logic [1:0][63:0]   cnt_ext;

  assign pend[0] = mie_q[11] & mip_q[11];
  assign pend[1] = mie_q[3]  & mip_q[3];
  assign pend[2] = mie_q[7]  & mip_q[7];
  for (genvar gi = 0; gi < N_LOCAL; gi++) begin : gen_pend
    assign pend[3+gi] = mie_q[16+gi] & mip_q[16+gi];
  end

  csr_irq_arb #(.N_LOCAL(N_LOCAL)) u_arb (
    .pend_i  (pend),
    .valid_o (irq_valid),
    .code_o  (irq_code)
  );

  assign take_irq  = mstatus_q.mie & irq_valid & retire & ~exc & ~mret;
  assign take_trap = exc | take_irq;
  assign do_mret   = mret & ~exc;
  assign mip_d     = {16'(lirq), 4'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0} & IRQ_MASK;

  always_comb begin
    mstatus_d  = mstatus_q;
    mtvec_d    = mtvec_q;
    mie_d      = mie_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcntinh_d  = mcntinh_q;
    trap_pc_d  = trap_pc_q;
    if (wren) begin
      case (waddr)
        CSR_MSTATUS:  mstatus_d  = '{mpie: wdata[7], mie: wdata[3]};
        CSR_MTVEC:    mtvec_d    = mtvec_legalise(wdata);
        CSR_MIE:      mie_d      = wdata & IRQ_MASK;
        CSR_MSCRATCH: mscratch_d = wdata;
        CSR_MEPC:     mepc_d     = {wdata[31:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = wdata;
        CSR_MTVAL:    mtval_d    = wdata;
        CSR_MCNTINH:  mcntinh_d  = wdata & 32'h0000_0005;
        default: ;
      endcase
    end
    // Trap and mret state updates override a same-cycle CSR write.
    if (take_trap) begin
      mstatus_d = '{mpie: mstatus_q.mie, mie: 1'b0};
      mepc_d    = {epc[31:2], 2'b00};
      mcause_d  = {take_irq, 26'b0, (exc ? ecause : irq_code)};
      mtval_d   = exc ? etval : 32'h0;
      if (take_irq && mtvec_q.mode == 2'b01)
        trap_pc_d = {mtvec_q.base, 2'b00} + {25'b0, irq_code, 2'b00};
      else
        trap_pc_d = {mtvec_q.base, 2'b00};
    end else if (do_mret) begin
      mstatus_d = '{mpie: 1'b1, mie: mstatus_q.mpie};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mstatus_q  <= MSTATUS_INIT;
      mtvec_q    <= mtvec_t'(RST_MTVEC);
      mie_q      <= '0;
      mip_q      <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcntinh_q  <= '0;
      trap_q     <= 1'b0;
      ret_q      <= 1'b0;
      trap_pc_q  <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mtvec_q    <= mtvec_d;
      mie_q      <= mie_d;
      mip_q      <= mip_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcntinh_q  <= mcntinh_d;
      trap_q     <= take_trap;
      ret_q      <= do_mret;
      trap_pc_q  <= trap_pc_d;
    end
  end

  // Counter 0 is mcycle, counter 1 is minstret; a write to one half replaces
  // that half and leaves the other untouched, with no carry.
  for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
    localparam logic [11:0] LO_ADDR = (gi == 0) ? CSR_MCYCLE  : CSR_MINSTRET;
    localparam logic [11:0] HI_ADDR = (gi == 0) ? CSR_MCYCLEH : CSR_MINSTRETH;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [63:0]          wr_val;
    logic                 inc;

    assign inc         = (gi == 0) ? ~mcntinh_q[0] : (retire & ~mcntinh_q[2]);
    assign cnt_ext[gi] = 64'(cnt_q);

    always_comb begin
      wr_val = 64'(cnt_q);
      cnt_d  = cnt_q;
      if (inc) cnt_d = cnt_q + CNT_WIDTH'(1);
      if (wren && waddr == LO_ADDR) begin
        wr_val[31:0] = wdata;
        cnt_d        = wr_val[CNT_WIDTH-1:0];
      end else if (HAS_HI && wren && waddr == HI_ADDR) begin
        wr_val[63:32] = wdata;
        cnt_d         = wr_val[CNT_WIDTH-1:0];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (rden) begin
      case (raddr)
        CSR_MSTATUS:   rdata = mstatus_read(mstatus_q);
        CSR_MISA:      rdata = MISA_VAL;
        CSR_MIE:       rdata = mie_q;
        CSR_MIP:       rdata = mip_q;
        CSR_MTVEC:     rdata = mtvec_q;
        CSR_MSCRATCH:  rdata = mscratch_q;
        CSR_MEPC:      rdata = mepc_q;
        CSR_MCAUSE:    rdata = mcause_q;
        CSR_MTVAL:     rdata = mtval_q;
        CSR_MCNTINH:   rdata = mcntinh_q;
        CSR_MCYCLE:    rdata = cnt_ext[0][31:0];
        CSR_MCYCLEH:   rdata = cnt_ext[0][63:32];
        CSR_MINSTRET:  rdata = cnt_ext[1][31:0];
        CSR_MINSTRETH: rdata = cnt_ext[1][63:32];
        default:       rdata = 32'h0;
      endcase
    end
  end

  assign trap    = trap_q;
  assign ret     = ret_q;
  assign trap_pc = trap_pc_q;
  assign mepc_o  = mepc_q;

endmodule

// File: tb/tb_csr_mtrap.sv
// Directed bench for csr_mtrap: reset state, interrupts, vectoring,
// exceptions, mret, counter writes/wrap and mcountinhibit.
module tb_csr_mtrap;
  import csr_mtrap_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rden = 1'b0, wren = 1'b0;
  logic [11:0] raddr = '0, waddr = '0;
  logic [31:0] rdata, wdata = '0;
  logic        retire = 1'b0, exc = 1'b0, mret = 1'b0;
  logic [4:0]  ecause = '0;
  logic [31:0] epc = '0, etval = '0;
  logic        meip = 1'b0, mtip = 1'b0, msip = 1'b0;
  logic [15:0] lirq = '0;
  logic        trap, ret;
  logic [31:0] trap_pc, mepc_o;

  int errors = 0;
  int checks = 0;

  csr_mtrap #(.N_LOCAL(16), .CNT_WIDTH(64), .RST_MTVEC(32'h0)) dut (
    .clk(clk), .rst(rst), .rden(rden), .raddr(raddr), .rdata(rdata),
    .wren(wren), .waddr(waddr), .wdata(wdata), .retire(retire), .exc(exc),
    .ecause(ecause), .epc(epc), .etval(etval), .mret(mret), .meip(meip),
    .mtip(mtip), .msip(msip), .lirq(lirq), .trap(trap), .ret(ret),
    .trap_pc(trap_pc), .mepc_o(mepc_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    rden = 1'b1; raddr = a;
    #1;
    d = rdata;
    rden = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wren = 1'b1; waddr = a; wdata = d;
    tick();
    wren = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    checks++; if (trap !== 1'b0 || ret !== 1'b0) begin errors++; $display("FAIL reset_pulses: got trap=%b ret=%b want 0 0", trap, ret); end
    checks++; if (trap_pc !== 32'h0) begin errors++; $display("FAIL reset_trap_pc: got %08h want 00000000", trap_pc); end
    rd(CSR_MTVEC, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mtvec: got %08h want 00000000", d); end
    rd(CSR_MISA, d);
    checks++; if (d !== 32'h4000_1100) begin errors++; $display("FAIL reset_misa: got %08h want 40001100", d); end
    rd(CSR_MSTATUS, d);
    checks++; if (d !== 32'h0000_1800) begin errors++; $display("FAIL reset_mstatus: got %08h want 00001800", d); end
    raddr = CSR_MISA; #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rden_low: got %08h want 00000000", rdata); end
    rd(12'h7C0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unimpl_read: got %08h want 00000000", d); end
    rd(CSR_MCYCLE, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL mcycle_start: got %0d want 0", d); end
    repeat (10) tick();
    rd(CSR_MCYCLE, d);
    checks++; if (d !== 32'd10) begin errors++; $display("FAIL mcycle_10: got %0d want 10", d); end
    $display("test_reset done");
  endtask

  task automatic test_mip();
    logic [31:0] d;
    msip = 1'b1;
    rd(CSR_MIP, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mip_latency: got %08h want 00000000", d); end
    tick();
    rd(CSR_MIP, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL mip_msip: got %08h want 00000008", d); end
    wr(CSR_MIP, 32'h0);
    rd(CSR_MIP, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL mip_write_ignored: got %08h want 00000008", d); end
    msip = 1'b0; lirq = 16'h0001;
    tick();
    rd(CSR_MIP, d);
    checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL mip_lirq0: got %08h want 00010000", d); end
    lirq = '0;
    tick();
    $display("test_mip done");
  endtask

  task automatic test_irq();
    logic [31:0] d;
    wr(CSR_MSTATUS, 32'h8);
    wr(CSR_MIE, 32'h880);
    meip = 1'b1; mtip = 1'b1;
    tick();
    retire = 1'b1; epc = 32'h100; etval = 32'h1234;
    tick();
    retire = 1'b0;
    checks++; if (trap !== 1'b1) begin errors++; $display("FAIL irq_trap: got %b want 1", trap); end
    checks++; if (mepc_o !== 32'h100) begin errors++; $display("FAIL irq_mepc: got %08h want 00000100", mepc_o); end
    rd(CSR_MCAUSE, d);
    checks++; if (d !== 32'h8000_000B) begin errors++; $display("FAIL irq_mcause: got %08h want 8000000b", d); end
    rd(CSR_MSTATUS, d);
    checks++; if (d !== 32'h0000_1880) begin errors++; $display("FAIL irq_mstatus: got %08h want 00001880", d); end
    rd(CSR_MTVAL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL irq_mtval: got %08h want 00000000", d); end
    meip = 1'b0; mtip = 1'b0;
    tick();
    checks++; if (trap !== 1'b0) begin errors++; $display("FAIL irq_pulse_len: got %b want 0", trap); end
    $display("test_irq done");
  endtask

  task automatic test_mret();
    logic [31:0] d;
    mret = 1'b1;
    tick();
    mret = 1'b0;
    checks++; if (ret !== 1'b1 || trap !== 1'b0) begin errors++; $display("FAIL mret_pulse: got ret=%b trap=%b want 1 0", ret, trap); end
    rd(CSR_MSTATUS, d);
    checks++; if (d !== 32'h0000_1888) begin errors++; $display("FAIL mret_mstatus: got %08h want 00001888", d); end
    tick();
    checks++; if (ret !== 1'b0) begin errors++; $display("FAIL mret_pulse_len: got %b want 0", ret); end
    $display("test_mret done");
  endtask

  task automatic test_vectored();
    logic [31:0] d;
    wr(CSR_MTVEC, 32'h2003);
    rd(CSR_MTVEC, d);
    checks++; if (d !== 32'h2000) begin errors++; $display("FAIL mtvec_warl: got %08h want 00002000", d); end
    wr(CSR_MTVEC, 32'h1001);
    rd(CSR_MTVEC, d);
    checks++; if (d !== 32'h1001) begin errors++; $display("FAIL mtvec_vec: got %08h want 00001001", d); end
    wr(CSR_MIE, 32'h0004_0000);
    lirq = 16'h0004;
    tick();
    retire = 1'b1; epc = 32'h200; etval = 32'h55;
    tick();
    retire = 1'b0; lirq = '0;
    checks++; if (trap !== 1'b1 || trap_pc !== 32'h1048) begin errors++; $display("FAIL vec_trap_pc: got trap=%b pc=%08h want 1 00001048", trap, trap_pc); end
    rd(CSR_MCAUSE, d);
    checks++; if (d !== 32'h8000_0012) begin errors++; $display("FAIL vec_mcause: got %08h want 80000012", d); end
    mret = 1'b1;
    tick();
    mret = 1'b0;
    tick();
    $display("test_vectored done");
  endtask

  task automatic test_exc();
    logic [31:0] d;
    wr(CSR_MIE, 32'h800);
    meip = 1'b1;
    tick();
    exc = 1'b1; ecause = 5'd2; retire = 1'b1; epc = 32'h300; etval = 32'hDEAD_BEEF;
    tick();
    exc = 1'b0; retire = 1'b0; meip = 1'b0;
    checks++; if (trap !== 1'b1 || trap_pc !== 32'h1000) begin errors++; $display("FAIL exc_trap_pc: got trap=%b pc=%08h want 1 00001000", trap, trap_pc); end
    rd(CSR_MCAUSE, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL exc_mcause: got %08h want 00000002", d); end
    rd(CSR_MTVAL, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL exc_mtval: got %08h want deadbeef", d); end
    checks++; if (mepc_o !== 32'h300) begin errors++; $display("FAIL exc_mepc: got %08h want 00000300", mepc_o); end
    tick();
    // exc + mret + CSR write to mepc all in one cycle
    exc = 1'b1; mret = 1'b1; ecause = 5'd5; epc = 32'h400;
    wren = 1'b1; waddr = CSR_MEPC; wdata = 32'h999;
    tick();
    exc = 1'b0; mret = 1'b0; wren = 1'b0;
    checks++; if (trap !== 1'b1 || ret !== 1'b0) begin errors++; $display("FAIL exc_mret_same: got trap=%b ret=%b want 1 0", trap, ret); end
    checks++; if (mepc_o !== 32'h400) begin errors++; $display("FAIL trap_over_write: got %08h want 00000400", mepc_o); end
    tick();
    wr(CSR_MSCRATCH, 32'hA5A5_0F0F);
    rd(CSR_MSCRATCH, d);
    checks++; if (d !== 32'hA5A5_0F0F) begin errors++; $display("FAIL mscratch: got %08h want a5a50f0f", d); end
    $display("test_exc done");
  endtask

  task automatic test_counter_write();
    logic [31:0] d, i0;
    wr(CSR_MIE, 32'h0);
    wr(CSR_MCYCLEH, 32'h12);
    wr(CSR_MCYCLE, 32'hFFFF_FFFF);
    wr(CSR_MCYCLE, 32'h5);
    rd(CSR_MCYCLE, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL cyc_write_wins: got %08h want 00000005", d); end
    rd(CSR_MCYCLEH, d);
    checks++; if (d !== 32'h12) begin errors++; $display("FAIL cyc_hi_hold: got %08h want 00000012", d); end
    wr(CSR_MCYCLE, 32'hFFFF_FFFF);
    tick();
    rd(CSR_MCYCLE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL cyc_wrap_lo: got %08h want 00000000", d); end
    rd(CSR_MCYCLEH, d);
    checks++; if (d !== 32'h13) begin errors++; $display("FAIL cyc_wrap_hi: got %08h want 00000013", d); end
    rd(CSR_MINSTRET, i0);
    retire = 1'b1;
    repeat (3) tick();
    retire = 1'b0;
    rd(CSR_MINSTRET, d);
    checks++; if (d !== i0 + 32'd3) begin errors++; $display("FAIL minstret_count: got %0d want %0d", d, i0 + 32'd3); end
    $display("test_counter_write done");
  endtask

  task automatic test_inhibit();
    logic [31:0] d, c0, i0;
    wr(CSR_MCNTINH, 32'h5);
    rd(CSR_MCNTINH, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL mcntinh_read: got %08h want 00000005", d); end
    rd(CSR_MCYCLE, c0);
    rd(CSR_MINSTRET, i0);
    retire = 1'b1;
    repeat (20) tick();
    retire = 1'b0;
    rd(CSR_MCYCLE, d);
    checks++; if (d !== c0) begin errors++; $display("FAIL inh_mcycle: got %0d want %0d", d, c0); end
    rd(CSR_MINSTRET, d);
    checks++; if (d !== i0) begin errors++; $display("FAIL inh_minstret: got %0d want %0d", d, i0); end
    wr(CSR_MCNTINH, 32'h0);
    retire = 1'b1;
    repeat (3) tick();
    retire = 1'b0;
    rd(CSR_MCYCLE, d);
    checks++; if (d !== c0 + 32'd3) begin errors++; $display("FAIL resume_mcycle: got %0d want %0d", d, c0 + 32'd3); end
    rd(CSR_MINSTRET, d);
    checks++; if (d !== i0 + 32'd3) begin errors++; $display("FAIL resume_minstret: got %0d want %0d", d, i0 + 32'd3); end
    $display("test_inhibit done");
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    exc = 1'b1; ecause = 5'd7;
    rst = 1'b0;
    tick();
    exc = 1'b0; rst = 1'b1;
    checks++; if (trap !== 1'b0 || ret !== 1'b0) begin errors++; $display("FAIL rst_mid_pulse: got trap=%b ret=%b want 0 0", trap, ret); end
    rd(CSR_MCAUSE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_mcause: got %08h want 00000000", d); end
    rd(CSR_MTVEC, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_mtvec: got %08h want 00000000", d); end
    tick();
    checks++; if (trap !== 1'b0) begin errors++; $display("FAIL rst_mid_after: got %b want 0", trap); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_mip();
    test_irq();
    test_mret();
    test_vectored();
    test_exc();
    test_counter_write();
    test_inhibit();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
